// File: rtl/store_slice_stage.sv
// Store slice stage: aligns execute-stage store data onto the 32-bit dmem bus and runs the write handshake.
// Define STORE_MISALIGN_SPLIT_EN to split word-crossing stores into two writes; otherwise they raise store_err_o.
module store_slice_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [1:0]        size_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    output logic              done_o,
    output logic              store_err_o,
    output logic [1:0]        state_o
);

    // Handshake: a store is taken when valid_i & ready_o & ~flush_i; a dmem beat completes when dmem_req_o & dmem_gnt_i.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              illegal, split, bad, accept, take, gnt_first;
    logic [4:0]        sh;
    logic [7:0]        be_wide;
    logic [31:0]       data_j, b1_data;
    logic [ADDR_W-1:0] b1_addr;

`ifdef STORE_MISALIGN_SPLIT_EN
    logic [63:0]       data_wide;
    logic              split_q;
    logic [ADDR_W-1:0] b2_addr_q;
    logic [3:0]        b2_be_q;
    logic [31:0]       b2_data_q;
`endif

    // Lane mask and data shifted across an 8-byte window; the upper half is the second beat.
    always_comb begin
        sh      = {addr_i[1:0], 3'b000};
        illegal = (size_i == 2'b11);
        be_wide = 8'b0000_1111 << addr_i[1:0];
        data_j  = wdata_i;
        case (size_i)
            2'b00: begin
                be_wide = 8'b0000_0001 << addr_i[1:0];
                data_j  = {24'b0, wdata_i[7:0]};
            end
            2'b01: begin
                be_wide = 8'b0000_0011 << addr_i[1:0];
                data_j  = {16'b0, wdata_i[15:0]};
            end
            default: ;
        endcase
        split   = (|be_wide[7:4]) & ~illegal;
        b1_addr = {addr_i[ADDR_W-1:2], 2'b00};
`ifdef STORE_MISALIGN_SPLIT_EN
        data_wide = {32'b0, data_j} << sh;
        b1_data   = (size_i == 2'b00) ? {4{wdata_i[7:0]}} : data_wide[31:0];
        bad       = illegal;
`else
        b1_data   = (size_i == 2'b00) ? {4{wdata_i[7:0]}} : (data_j << sh);
        bad       = illegal | split;
`endif
    end

    assign accept    = (state_q == IDLE) & valid_i & ~flush_i;
    assign take      = accept & ~bad;
    assign gnt_first = (state_q == FIRST) & dmem_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A grant in FIRST wins over a same-cycle flush; SECOND ignores flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (take) state_d = FIRST;
            FIRST: begin
                if (dmem_gnt_i) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                    state_d = split_q ? SECOND : IDLE;
`else
                    state_d = IDLE;
`endif
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            SECOND: if (dmem_gnt_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o    = (state_q == IDLE);
        stall_o    = ~ready_o;
        dmem_req_o = (state_q == FIRST) || (state_q == SECOND);
        dmem_we_o  = dmem_req_o;
        state_o    = state_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            done_o       <= 1'b0;
            store_err_o  <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
            split_q      <= 1'b0;
            b2_addr_q    <= '0;
            b2_be_q      <= '0;
            b2_data_q    <= '0;
`endif
        end else begin
            store_err_o <= accept & bad;
`ifdef STORE_MISALIGN_SPLIT_EN
            done_o <= (gnt_first & ~split_q) | ((state_q == SECOND) & dmem_gnt_i);
`else
            done_o <= gnt_first;
`endif
            if (take) begin
                dmem_addr_o  <= b1_addr;
                dmem_be_o    <= be_wide[3:0];
                dmem_wdata_o <= b1_data;
`ifdef STORE_MISALIGN_SPLIT_EN
                split_q      <= split;
                b2_addr_q    <= b1_addr + ADDR_W'(4);
                b2_be_q      <= be_wide[7:4];
                b2_data_q    <= data_wide[63:32];
            end else if (gnt_first && split_q) begin
                dmem_addr_o  <= b2_addr_q;
                dmem_be_o    <= b2_be_q;
                dmem_wdata_o <= b2_data_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_store_slice_stage.sv
// Directed bench for store_slice_stage: a vector table of single stores plus hand-written handshake corner cases.
module tb_store_slice_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i, flush_i, dmem_gnt_i;
    logic [31:0] addr_i, wdata_i;
    logic [1:0]  size_i;
    logic        ready_o, stall_o, dmem_req_o, dmem_we_o, done_o, store_err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    store_slice_stage #(.ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .size_i(size_i), .flush_i(flush_i), .ready_o(ready_o),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .done_o(done_o), .store_err_o(store_err_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          split;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic [31:0] a2;
        logic [3:0]  be2;
        logic [31:0] d2;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        check({tag, "_req"}, {31'b0, dmem_req_o}, 32'd1);
        check({tag, "_we"}, {31'b0, dmem_we_o}, 32'd1);
        check({tag, "_addr"}, dmem_addr_o, a);
        check({tag, "_be"}, {28'b0, dmem_be_o}, {28'b0, be});
        check({tag, "_wdata"}, dmem_wdata_o, d);
        check({tag, "_ready"}, {31'b0, ready_o}, 32'd0);
        check({tag, "_stall"}, {31'b0, stall_o}, 32'd1);
        check({tag, "_done"}, {31'b0, done_o}, 32'd0);
    endtask

    task automatic drive_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        valid_i = 1'b1;
        size_i  = sz;
        addr_i  = a;
        wdata_i = d;
        step();
        valid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0; dmem_gnt_i = 1'b0;
        addr_i = '0; wdata_i = '0; size_i = '0;

        vecs[0]  = '{2'b00, 32'h0000_1002, 32'h0000_00AB, 1'b0, 32'h0000_1000, 4'b0100, 32'hABAB_ABAB, 32'h0, 4'h0, 32'h0};
        vecs[1]  = '{2'b10, 32'h0000_2001, 32'h1122_3344, 1'b1, 32'h0000_2000, 4'b1110, 32'h2233_4400, 32'h0000_2004, 4'b0001, 32'h0000_0011};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF, 1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000, 32'h0000_0000, 4'b0001, 32'h0000_00BE};
        vecs[3]  = '{2'b01, 32'h0000_3002, 32'h0000_ABCD, 1'b0, 32'h0000_3000, 4'b1100, 32'hABCD_0000, 32'h0, 4'h0, 32'h0};
        vecs[4]  = '{2'b01, 32'h0000_3001, 32'h0000_5A5A, 1'b0, 32'h0000_3000, 4'b0110, 32'h005A_5A00, 32'h0, 4'h0, 32'h0};
        vecs[5]  = '{2'b10, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0};
        vecs[6]  = '{2'b10, 32'h0000_5003, 32'hA1B2_C3D4, 1'b1, 32'h0000_5000, 4'b1000, 32'hD400_0000, 32'h0000_5004, 4'b0111, 32'h00A1_B2C3};
        vecs[7]  = '{2'b10, 32'h0000_6002, 32'hCAFE_F00D, 1'b1, 32'h0000_6000, 4'b1100, 32'hF00D_0000, 32'h0000_6004, 4'b0011, 32'h0000_CAFE};
        vecs[8]  = '{2'b11, 32'h0000_7000, 32'h1234_5678, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[9]  = '{2'b00, 32'h0000_0003, 32'h1234_56C3, 1'b0, 32'h0000_0000, 4'b1000, 32'hC3C3_C3C3, 32'h0, 4'h0, 32'h0};
        vecs[10] = '{2'b10, 32'hFFFF_FFFE, 32'h89AB_CDEF, 1'b1, 32'hFFFF_FFFC, 4'b1100, 32'hCDEF_0000, 32'h0000_0000, 4'b0011, 32'h0000_89AB};

        // Reset values
        #3;
        check("rst_req", {31'b0, dmem_req_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_err", {31'b0, store_err_o}, 32'd0);
        check("rst_addr", dmem_addr_o, 32'd0);
        check("rst_be", {28'b0, dmem_be_o}, 32'd0);
        check("rst_wdata", dmem_wdata_o, 32'd0);
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        #4 rst_ni = 1'b1;
        step();

        // Table of single stores with grant held high
        foreach (vecs[i]) begin
            bit exp_err;
            exp_err = (vecs[i].size == 2'b11) || (vecs[i].split && !SPLIT_EN);
            dmem_gnt_i = 1'b1;
            drive_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
            if (exp_err) begin
                check($sformatf("v%0d_err_pulse", i), {31'b0, store_err_o}, 32'd1);
                check($sformatf("v%0d_err_noreq", i), {31'b0, dmem_req_o}, 32'd0);
                check($sformatf("v%0d_err_ready", i), {31'b0, ready_o}, 32'd1);
                step();
                check($sformatf("v%0d_err_once", i), {31'b0, store_err_o}, 32'd0);
                check($sformatf("v%0d_err_noreq2", i), {31'b0, dmem_req_o}, 32'd0);
            end else begin
                check($sformatf("v%0d_noerr", i), {31'b0, store_err_o}, 32'd0);
                check_beat($sformatf("v%0d_b1", i), vecs[i].a1, vecs[i].be1, vecs[i].d1);
                step();
                if (vecs[i].split) begin
                    check_beat($sformatf("v%0d_b2", i), vecs[i].a2, vecs[i].be2, vecs[i].d2);
                    step();
                end
                check($sformatf("v%0d_done", i), {31'b0, done_o}, 32'd1);
                check($sformatf("v%0d_ready", i), {31'b0, ready_o}, 32'd1);
                check($sformatf("v%0d_req_low", i), {31'b0, dmem_req_o}, 32'd0);
                step();
                check($sformatf("v%0d_done_once", i), {31'b0, done_o}, 32'd0);
            end
        end

        // Grant while idle is ignored
        dmem_gnt_i = 1'b1;
        step();
        check("idle_gnt_req", {31'b0, dmem_req_o}, 32'd0);
        check("idle_gnt_done", {31'b0, done_o}, 32'd0);

        // Grant withheld three cycles on an aligned word
        begin
            int done_cnt;
            done_cnt = 0;
            dmem_gnt_i = 1'b0;
            drive_store(2'b10, 32'h0000_0040, 32'h0102_0304);
            for (int k = 0; k < 4; k++) begin
                check_beat($sformatf("hold%0d", k), 32'h0000_0040, 4'b1111, 32'h0102_0304);
                if (k == 3) dmem_gnt_i = 1'b1;
                step();
                if (done_o) done_cnt++;
            end
            dmem_gnt_i = 1'b0;
            step();
            if (done_o) done_cnt++;
            check("hold_done_count", done_cnt, 32'd1);
            check("hold_ready", {31'b0, ready_o}, 32'd1);
        end

        // Flush in FIRST before grant abandons the store
        drive_store(2'b00, 32'h0000_0010, 32'h0000_0055);
        check("flush1_req", {31'b0, dmem_req_o}, 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush1_req_drop", {31'b0, dmem_req_o}, 32'd0);
        check("flush1_ready", {31'b0, ready_o}, 32'd1);
        check("flush1_nodone", {31'b0, done_o}, 32'd0);
        dmem_gnt_i = 1'b1;
        step();
        check("flush1_nodone2", {31'b0, done_o}, 32'd0);

        // Flush together with the first grant: the grant wins
        drive_store(2'b01, 32'h0000_0020, 32'h0000_1234);
        check_beat("flushg", 32'h0000_0020, 4'b0011, 32'h0000_1234);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flushg_done", {31'b0, done_o}, 32'd1);

        // Store offered with flush is dropped
        valid_i = 1'b1; flush_i = 1'b1; size_i = 2'b10; addr_i = 32'h80; wdata_i = 32'h5;
        step();
        valid_i = 1'b0; flush_i = 1'b0;
        check("drop_req", {31'b0, dmem_req_o}, 32'd0);
        check("drop_err", {31'b0, store_err_o}, 32'd0);
        check("drop_ready", {31'b0, ready_o}, 32'd1);

`ifdef STORE_MISALIGN_SPLIT_EN
        // Flush in SECOND is ignored
        dmem_gnt_i = 1'b1;
        drive_store(2'b10, 32'h0000_2001, 32'h1122_3344);
        step();
        dmem_gnt_i = 1'b0; flush_i = 1'b1;
        check_beat("flush2_b2", 32'h0000_2004, 4'b0001, 32'h0000_0011);
        step();
        flush_i = 1'b0;
        check_beat("flush2_held", 32'h0000_2004, 4'b0001, 32'h0000_0011);
        dmem_gnt_i = 1'b1;
        step();
        check("flush2_done", {31'b0, done_o}, 32'd1);
`endif

        // Reset mid-store drops req asynchronously
        dmem_gnt_i = 1'b0;
        drive_store(2'b10, 32'h0000_0100, 32'hFFFF_0000);
        check("arst_req_before", {31'b0, dmem_req_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_req", {31'b0, dmem_req_o}, 32'd0);
        check("arst_addr", dmem_addr_o, 32'd0);
        check("arst_ready", {31'b0, ready_o}, 32'd1);
        #1 rst_ni = 1'b1;
        step();
        check("arst_nodone", {31'b0, done_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_slice_stage.md
Name: store_slice_stage

Overview:
- Store-side counterpart of the load data extraction in the memory stage.
- Takes one store (address, data, size) from execute, aligns the data onto the 32-bit data-memory bus and generates byte enables.
- Drives the dmem write request/grant handshake; a store that crosses a word boundary is split into two word-aligned writes.
- Stalls the pipeline while a store is in flight.

Parameters:
- ADDR_W, 32, byte-address width; dmem_addr_o is word aligned, so bits [1:0] are always 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  store request from execute; qualified by ready_o
- addr_i  in  ADDR_W  store byte address
- wdata_i  in  32  store data, right-justified
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- flush_i  in  1  pipeline flush
- ready_o  out  1  stage can accept a store this cycle
- stall_o  out  1  store in flight; equals ~ready_o
- dmem_req_o  out  1  write request
- dmem_we_o  out  1  write enable; equals dmem_req_o
- dmem_addr_o  out  ADDR_W  word-aligned write address
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned write data
- dmem_gnt_i  in  1  grant; the transfer completes in the cycle req and gnt are both high
- done_o  out  1  one-cycle pulse when the store has fully retired
- store_err_o  out  1  one-cycle pulse: illegal size, or misaligned with splitting disabled

Behaviour:
- Reset (async, rst_ni low): state IDLE; dmem_req_o, done_o, store_err_o = 0; dmem_addr_o, dmem_be_o, dmem_wdata_o = 0.
- FSM states are IDLE, FIRST and SECOND. ready_o = (state == IDLE).
- IDLE, valid_i & ~flush_i: latch the computed first and second beats.
  - size 11: stay IDLE, pulse store_err_o next cycle, no request issued.
  - otherwise: go to FIRST; dmem_req_o rises the cycle after acceptance, so request latency is 1.
- IDLE, valid_i & flush_i: input dropped, nothing issued.
- Let o = addr_i[1:0]. A store splits when (half and o == 3) or (word and o != 0).
- Byte:
  - be = 0001 << o
  - wdata = byte replicated in all four lanes
- Half, no split:
  - be = 0011 << o
  - wdata = wdata_i << 8·o
- Half at o == 3:
  - beat 1: be 1000, wdata_i[7:0] in [31:24]
  - beat 2: be 0001, wdata_i[15:8] in [7:0]
- Word split:
  - beat 1: be = (1111 << o)[3:0], data = wdata_i << 8·o
  - beat 2: be = 1111 >> (4−o), data = wdata_i >> 8·(4−o)
- Beat 1 address = {addr_i[ADDR_W-1:2], 00}. Beat 2 address = beat 1 address + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC goes to 0x00000000).
- Request outputs are registered and held stable from req rise until grant. dmem_gnt_i is ignored while req is low.
- FIRST with grant:
  - split: go to SECOND; beat 2 is presented the next cycle.
  - no split: go to IDLE; done_o pulses the next cycle.
- SECOND with grant: go to IDLE; done_o pulses the next cycle.
- Throughput: at most one store per 2 cycles; done_o coincides with ready_o = 1.
- flush_i in FIRST before grant: the store is abandoned; req drops the next cycle, state returns to IDLE, no done_o.
- flush_i in the same cycle as the FIRST grant: the grant wins and the beat counts as written.
- flush_i in SECOND is ignored; beat 2 must complete so no half-written word is left behind.
- Grant held high continuously: each beat takes exactly 1 cycle in FIRST/SECOND.
- Reset asserted mid-store: everything is abandoned immediately and req drops asynchronously.

Optional Feature:
- Macro STORE_MISALIGN_SPLIT_EN.
- Defined: splitting as described above.
- Undefined:
  - SECOND state is not synthesized.
  - A store that would split is accepted, no request is issued, and store_err_o pulses the cycle after acceptance.
  - Aligned stores behave identically in both builds.

Test Plan:
- Byte store, addr 0x1002, wdata 0xAB, grant immediate:
  - req the cycle after accept
  - addr 0x1000, be 0100, wdata 0xABABABAB
  - done_o 2 cycles after accept
- Word store, addr 0x2001, wdata 0x11223344:
  - beat 1: addr 0x2000, be 1110, wdata 0x22334400
  - beat 2: addr 0x2004, be 0001, wdata 0x00000011
  - done_o one cycle after the second grant
- Half store, addr 0xFFFFFFFF, wdata 0xBEEF, with the split macro:
  - beat 1: addr 0xFFFFFFFC, be 1000, data[31:24] = EF
  - beat 2: addr 0x00000000, be 0001, data[7:0] = BE
- Grant withheld 3 cycles on an aligned word at 0x40:
  - req, addr, be and wdata held stable for 4 cycles
  - done_o once; ready_o low throughout
- Flush:
  - flush_i in FIRST before grant: req drops, no done_o
  - flush_i in SECOND: beat 2 is still written and done_o pulses
- size_i = 11, or a misaligned word with the macro undefined: store_err_o one pulse, dmem_req_o never asserted.
